// File: rtl/conversor_bcd_bin_seq_if.sv
// rtl/conversor_bcd_bin_seq_if.sv - start/busy/done handshake and data bus of the BCD<->binary converter
interface conversor_bcd_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic                  mode;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_in;
  logic [BIN_W-1:0]      bin_out;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, mode, bcd_in, bin_in,
    input  bin_out, bcd_out, busy, done, err
  );

  modport slave (
    input  start, mode, bcd_in, bin_in,
    output bin_out, bcd_out, busy, done, err
  );
endinterface

// File: rtl/conversor_bcd_bin_seq.sv
// rtl/conversor_bcd_bin_seq.sv - sequential BCD<->binary converter (mode 0: acc*10+digit, mode 1: double dabble)
// Define BCD_CHECK_EN to enable invalid-digit / overflow detection (err) and mode 1 saturation.
module conversor_bcd_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic clk,
  input  logic rst,
  conversor_bcd_bin_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  // Working BCD register is wide enough for any BIN_W-bit value, so the visible digits are exact or truncated.
  localparam int BD = (BIN_W + 2) / 3;
  localparam int DW = 4 * BD;
  localparam int AW = BIN_W + 4;
  localparam int CW = $clog2(BIN_W + DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t           state, state_n;
  logic             load, step, fin;
  logic             m;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, acc_n;
  logic [BW-1:0]    bsh;
  logic [3:0]       digit;
  logic [DW-1:0]    dd;
  logic [BIN_W-1:0] bsr;
  logic [DW+BIN_W-1:0] pair_n;
  logic             busy_r, done_r;
  logic [BIN_W-1:0] bin_r;
  logic [BW-1:0]    bcd_r;
`ifdef BCD_CHECK_EN
  logic             bad, err_r, ovf;
`endif

  function automatic logic [DW-1:0] dabble(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < BD; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load    = 1'b1;
        state_n = CONV;
      end
      CONV: begin
        step = 1'b1;
        if (cnt == '0) state_n = FIN;
      end
      FIN: begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign digit  = bsh[BW-1 -: 4];
  assign acc_n  = acc * AW'(10) + {{(AW-4){1'b0}}, digit};
  assign pair_n = {dabble(dd), bsr} << 1;
`ifdef BCD_CHECK_EN
  assign ovf    = |dd[DW-1:BW];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m      <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      bsh    <= '0;
      dd     <= '0;
      bsr    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bin_r  <= '0;
      bcd_r  <= '0;
`ifdef BCD_CHECK_EN
      bad    <= 1'b0;
      err_r  <= 1'b0;
`endif
    end else begin
      done_r <= fin;
      if (load) begin
        m      <= bus.mode;
        acc    <= '0;
        bsh    <= bus.bcd_in;
        dd     <= '0;
        bsr    <= bus.bin_in;
        cnt    <= bus.mode ? CW'(BIN_W - 1) : CW'(DIGITS - 1);
        busy_r <= 1'b1;
`ifdef BCD_CHECK_EN
        bad    <= 1'b0;
`endif
      end
      if (step) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (!m) begin
          acc <= acc_n;
          bsh <= bsh << 4;
`ifdef BCD_CHECK_EN
          bad <= bad | (digit > 4'd9);
`endif
        end else begin
          dd  <= pair_n[DW+BIN_W-1:BIN_W];
          bsr <= pair_n[BIN_W-1:0];
        end
      end
      if (fin) begin
        busy_r <= 1'b0;
        if (!m) bin_r <= acc[BIN_W-1:0];
`ifdef BCD_CHECK_EN
        else    bcd_r <= ovf ? {DIGITS{4'h9}} : dd[BW-1:0];
        err_r  <= m ? ovf : bad;
`else
        else    bcd_r <= dd[BW-1:0];
`endif
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bin_out = bin_r;
  assign bus.bcd_out = bcd_r;
`ifdef BCD_CHECK_EN
  assign bus.err     = err_r;
`else
  assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_conversor_bcd_bin_seq.sv
// tb/tb_conversor_bcd_bin_seq.sv - table + scoreboard bench for conversor_bcd_bin_seq (DIGITS=4, BIN_W=14)
module tb_conversor_bcd_bin_seq;
`ifdef BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [13:0] eb;
    logic [15:0] ed;
    logic        ee;
  } exp_t;

  typedef struct {
    logic        m;
    logic [15:0] bcd;
    logic [13:0] bin;
    logic [13:0] eb;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[10];
  logic [13:0] cur_bin;
  logic [15:0] cur_bcd;

  always #5 clk = ~clk;

  conversor_bcd_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();
  conversor_bcd_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("bin_out", 32'(bus.bin_out), 32'(mon_e.eb));
        chk("bcd_out", 32'(bus.bcd_out), 32'(mon_e.ed));
        chk("err", 32'(bus.err), 32'(mon_e.ee));
      end
    end
  end

  function automatic void model(input logic m, input logic [15:0] b, input logic [13:0] bi,
                                output logic [13:0] eb, output logic [15:0] ed, output logic ee);
    int a, d, v;
    eb = cur_bin;
    ed = cur_bcd;
    ee = 1'b0;
    if (!m) begin
      a = 0;
      for (int i = 3; i >= 0; i--) begin
        d = int'((b >> (4*i)) & 16'hF);
        a = a * 10 + d;
        if (d > 9) ee = CHK;
      end
      eb = 14'(a);
    end else begin
      v = int'(bi);
      if (CHK && v > 9999) begin
        ed = 16'h9999;
        ee = 1'b1;
      end else begin
        ed = '0;
        for (int i = 0; i < 4; i++) begin
          ed[4*i +: 4] = 4'(v % 10);
          v = v / 10;
        end
      end
    end
  endfunction

  task automatic wait_done(output int bc, output bit seen);
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the converter idle (or in its done cycle); returns at the done negedge.
  task automatic run(input logic m, input logic [15:0] b, input logic [13:0] bi,
                     input logic [13:0] eb, input logic [15:0] ed, input logic ee);
    int bc;
    bit seen;
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.bcd_in = b;
    bus.bin_in = bi;
    sb.push_back('{eb, ed, ee});
    cur_bin = eb;
    cur_bcd = ed;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mode   = ~m;
    bus.bcd_in = 16'($urandom);
    bus.bin_in = 14'($urandom);
    wait_done(bc, seen);
    chk("done_seen", 32'(seen), 1);
    chk("busy_cycles", 32'(bc), m ? 15 : 5);
  endtask

  initial begin
    int bc;
    bit seen;
    logic m;
    logic [15:0] b;
    logic [13:0] bi, eb;
    logic [15:0] ed;
    logic ee;

    tbl[0] = '{1'b0, 16'h9999, 14'd0,     14'd9999, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h0000, 14'd1234,  14'd9999, 16'h1234, 1'b0};
    tbl[2] = '{1'b1, 16'h0000, 14'd10000, 14'd9999, CHK ? 16'h9999 : 16'h0000, CHK};
    tbl[3] = '{1'b0, 16'h12A4, 14'd55,    14'd1304, CHK ? 16'h9999 : 16'h0000, CHK};
    tbl[4] = '{1'b1, 16'h0000, 14'd0,     14'd1304, 16'h0000, 1'b0};
    tbl[5] = '{1'b1, 16'h0000, 14'd9999,  14'd1304, 16'h9999, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 14'd3,     14'd0,    16'h9999, 1'b0};
    tbl[7] = '{1'b1, 16'h0000, 14'd16383, 14'd0,    CHK ? 16'h9999 : 16'h6383, CHK};
    tbl[8] = '{1'b0, 16'hFFFF, 14'd0,     14'd281,  CHK ? 16'h9999 : 16'h6383, CHK};
    tbl[9] = '{1'b1, 16'h0000, 14'd5,     14'd281,  16'h0005, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.bcd_in = '0;
    bus.bin_in = '0;
    cur_bin = '0;
    cur_bcd = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_bin", 32'(bus.bin_out), 0);
    chk("rst_bcd", 32'(bus.bcd_out), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run(tbl[i].m, tbl[i].bcd, tbl[i].bin, tbl[i].eb, tbl[i].ed, tbl[i].ee);

    for (int i = 0; i < 8; i++) begin
      m  = 1'($urandom);
      b  = 16'($urandom);
      bi = 14'($urandom);
      model(m, b, bi, eb, ed, ee);
      run(m, b, bi, eb, ed, ee);
    end

    // Start during busy must be ignored; the next start lands in the done cycle.
    bus.start  = 1'b1;
    bus.mode   = 1'b0;
    bus.bcd_in = 16'h0042;
    sb.push_back('{14'd42, cur_bcd, 1'b0});
    cur_bin = 14'd42;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = 1'b1;
    bus.bcd_in = 16'h0001;
    bus.bin_in = 14'd77;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc, seen);
    chk("ign_done_seen", 32'(seen), 1);
    chk("ign_busy_cycles", 32'(bc + 2), 5);
    run(1'b0, 16'h0007, 14'd123, 14'd7, cur_bcd, 1'b0);

    // Reset mid-conversion aborts with no done pulse.
    bus.start  = 1'b1;
    bus.mode   = 1'b0;
    bus.bcd_in = 16'h0123;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    cur_bin = '0;
    cur_bcd = '0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_bin", 32'(bus.bin_out), 0);
    chk("abort_bcd", 32'(bus.bcd_out), 0);
    chk("abort_err", 32'(bus.err), 0);
    repeat (10) @(negedge clk);
    run(1'b0, 16'h0007, 14'd0, 14'd7, 16'h0000, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
